// File: rtl/mips_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_unit_pkg
//  Description : Shared definitions for the MIPS instruction fetch stage:
//                word width, PC increment, default reset PC, fetch FSM
//                state encodings and the FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_unit_pkg;

    localparam int          c_instr_w          = 32;
    localparam logic [31:0] c_pc_inc           = 32'd4;
    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;

    // Fetch controller states (2-bit, registered)
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,   // normal sequential fetching
        ST_DRAIN = 2'b01,   // waiting out a stale request after a redirect
        ST_HALT  = 2'b10    // misaligned redirect seen; only reset leaves
    } fetch_state_t;

    // One buffered fetch: the instruction word and the PC it came from
    typedef struct packed {
        logic [c_instr_w-1:0] instr;
        logic [31:0]          pc;
    } fetch_entry_t;

    // Instruction addresses must be word aligned
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_unit_fifo
//  Description : Small synchronous FIFO buffering fetched instructions.
//                Head entry is read straight from the storage registers.
//  Ports       : clock/reset    - clock, async active-high reset
//                push/push_data - write an entry (ignored during flush)
//                pop            - drop the head entry (ignored when empty
//                                 or during flush)
//                flush          - empty the FIFO this edge
//                count          - number of valid entries
//                head           - oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Flush takes precedence over both push and pop
    assign w_do_push = push && !flush;
    assign w_do_pop  = pop && (r_count != '0) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues single
//                outstanding word reads to instruction memory, buffers the
//                returned words and hands {instruction, instr_pc} to the core
//                with valid/ready flow control. Redirects flush the buffer
//                and squash any in-flight fetch.
//  Ports       : clock, reset          - clock, async active-high reset
//                imem_req/addr         - memory read request (held until ack)
//                imem_ack/data         - memory response
//                redirect/redirect_pc  - PC change from the core
//                instruction/instr_pc  - buffered head entry
//                instr_valid/ready     - head handshake
//                err_misaligned        - sticky misaligned-redirect flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit
    import mips_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_default_reset_pc,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [c_instr_w-1:0] imem_data,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [c_instr_w-1:0] instruction,
    output logic [31:0]          instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 err_misaligned
);

    localparam int                 c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    fetch_state_t       r_state, w_state_next;
    logic [31:0]        r_pc, w_pc_next;
    logic [31:0]        r_addr, w_addr_next;
    logic               r_req, w_req_next;
    logic               r_err, w_err_next;
    logic               w_ack, w_pending;
    logic               w_push, w_pop, w_flush;
    logic [c_cnt_w-1:0] w_count, w_count_next;
    fetch_entry_t       w_head, w_push_entry;

    assign w_ack     = r_req && imem_ack;
    assign w_pending = r_req && !imem_ack;   // request stays open past this edge

    assign instr_valid  = (w_count != '0);
    assign w_pop        = instr_valid && instr_ready;
    // r_addr equals r_pc whenever a FETCH-state ack is accepted
    assign w_push_entry = '{instr: imem_data, pc: r_addr};

    // Next state / PC / buffer control
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_err_next   = r_err;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_FETCH, ST_DRAIN: begin
                if (redirect) begin
                    // Any ack arriving alongside a redirect is stale: never pushed
                    w_flush = 1'b1;
                    if (is_misaligned(redirect_pc[1:0])) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next    = redirect_pc;
                        w_state_next = w_pending ? ST_DRAIN : ST_FETCH;
                    end
                end else if (w_ack) begin
                    if (r_state == ST_FETCH) begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + c_pc_inc;
                    end else begin
                        // Stale response retired; resume from the redirected PC
                        w_state_next = ST_FETCH;
                    end
                end
            end
            default: begin
                // HALT: ignore everything until reset
            end
        endcase
    end

    // Occupancy after this edge, used to gate the next request so a push
    // can never land on a full buffer
    always_comb begin
        w_count_next = w_count;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = w_count + c_cnt_w'(1);
                2'b01:   w_count_next = w_count - c_cnt_w'(1);
                default: w_count_next = w_count;
            endcase
        end
    end

    // An open request holds req/addr in every state; otherwise a new one is
    // raised only while fetching with room in the buffer
    always_comb begin
        w_req_next  = w_pending || ((w_state_next == ST_FETCH) && (w_count_next < c_depth));
        w_addr_next = w_pending ? r_addr : w_pc_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_req   <= w_req_next;
            r_err   <= w_err_next;
        end
    end

    mips_fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .count     (w_count),
        .head      (w_head)
    );

    assign imem_req       = r_req;
    assign imem_addr      = r_addr;
    assign instruction    = w_head.instr;
    assign instr_pc       = w_head.pc;
    assign err_misaligned = r_err;

endmodule
`default_nettype wire
